cv32e40x_bch_resolve: RTL and testbench
=======================================

# cv32e40x_bch_resolve

Branch resolution unit in EX, the consumer of the ID-stage static branch prediction (backward-taken) and branch target. Captures the prediction, target and fall-through PC when a branch moves from ID to EX, compares them with the ALU branch decision, and on a misprediction flushes IF/ID and issues a held fetch redirect to IF. Optional performance counters track resolved branches and mispredictions.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous and active-high; one clock.
- id_valid_i  in  1  ID holds a valid instruction
- ex_ready_i  in  1  EX accepts from ID this cycle (ID->EX transfer = id_valid_i & ex_ready_i)
- bch_id_i  in  1  ID instruction is a conditional branch
- bch_prediction_id_i  in  1  static prediction from ID (1 = taken)
- bch_target_id_i  in  32  branch target from ID
- pc_id_i  in  32  PC of ID instruction
- instr_compressed_id_i  in  1  ID instruction is 16-bit
- ex_valid_i  in  1  ALU branch decision valid this cycle
- branch_decision_ex_i  in  1  actual outcome (1 = taken)
- kill_ex_i  in  1  controller kills EX (exception/interrupt/debug)
- redirect_ack_i  in  1  IF accepts redirect
- redirect_req_o  out  1  fetch redirect request
- redirect_pc_o  out  32  redirect address
- flush_if_id_o  out  1  flush IF and ID
- ex_stall_o  out  1  hold EX while redirect is unacknowledged
- bch_cnt_o  out  32  resolved branches (macro only)
- mispred_cnt_o  out  32  mispredictions (macro only)

## Operation
- EX register (bch_q, pred_q, target_q, fallthru_q) loads on ID->EX transfer; fallthru = pc_id_i + (compressed ? 2 : 4), mod 2^32. Transfer with bch_id_i=0 clears bch_q. bch_q clears on resolution, on kill_ex_i, or on rst.
- Resolution: bch_q & ex_valid_i & !kill_ex_i. mispredict = branch_decision_ex_i != pred_q.
- Correct prediction: no outputs; bch_q clears.
- Mispredict: redirect_pc = decision ? target_q : fallthru_q.
- FSM IDLE:
  - In the mispredict cycle, redirect_req_o=1 and flush_if_id_o=1 (combinational), with redirect_pc_o driven by the computed address.
  - If redirect_ack_i=1: stay IDLE. Otherwise latch the PC into pc_hold_q and go to WAIT.
- FSM WAIT:
  - redirect_req_o=1, redirect_pc_o=pc_hold_q, ex_stall_o=1, flush_if_id_o=1.
  - redirect_ack_i -> IDLE.
  - kill_ex_i -> IDLE with no request that cycle; the kill has priority over ack, and the controller owns the redirect.
- ex_stall_o=1 only in WAIT. ID->EX transfer is not expected in WAIT; if it occurs, it is ignored (EX register holds).
- redirect_pc_o = 0 whenever redirect_req_o=0.

## Timing
- Reset values: redirect_req_o=0, redirect_pc_o=0, flush_if_id_o=0, ex_stall_o=0, counters=0, FSM=IDLE, bch_q=0.
- Resolution to request: 0 cycles (same cycle as ex_valid_i). Request to ack: unbounded; the request is held stable until ack.
- The earliest next resolution is the cycle after the ack.
- rst mid-WAIT: returns to IDLE next edge, request dropped.

## Configuration
- CV32E40X_BCH_PERF_CNT_EN defined:
  - bch_cnt_o increments on every resolution.
  - mispred_cnt_o increments on every mispredict resolution.
  - Both are 32-bit wrapping, not incremented when kill_ex_i is high, and cleared by rst.
- Undefined: counter logic absent and both outputs tied to 0.

## Structure
- cv32e40x_pkg: typedef enum logic {BR_IDLE, BR_WAIT} bch_res_state_e.
- cv32e40x_pkg: localparams for PC increments, 32'd4 and 32'd2.
- Sub-module: cv32e40x_bch_perf_cnt, instantiated only under the macro, containing both counters.

## Test plan
- Backward branch at pc 0x100, target 0xF0, pred=1, decision=1 -> no redirect; bch_cnt_o=1, mispred_cnt_o=0.
- Forward branch at pc 0x200, 32-bit, pred=0, decision=1, target 0x240, ack same cycle -> redirect_req_o=1 with pc 0x240 and flush for one cycle; FSM stays IDLE.
- Backward branch at pc 0x300, compressed, pred=1, decision=0, ack held low 3 cycles -> pc 0x302 is held for 4 cycles with ex_stall_o=1 in the 3 WAIT cycles; IDLE after ack.
- Mispredict in WAIT with kill_ex_i=1 and ack=1 in the same cycle -> request dropped, IDLE.
- kill_ex_i during the resolution cycle -> no redirect, no count increment.
- Branch at pc 0xFFFFFFFC, 32-bit, pred=1, decision=0 -> redirect_pc_o=0x00000000 (wrap); rst during WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the EX-stage branch resolution logic.
package cv32e40x_pkg;

  typedef enum logic {BR_IDLE, BR_WAIT} bch_res_state_e;

  localparam logic [31:0] PC_INC_32 = 32'd4;
  localparam logic [31:0] PC_INC_16 = 32'd2;

endpackage

// File: rtl/cv32e40x_bch_perf_cnt.sv
// Resolved-branch and misprediction counters, both 32-bit wrapping.
// Only instantiated when CV32E40X_BCH_PERF_CNT_EN is defined.
module cv32e40x_bch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve,
  input  logic        mispredict,
  output logic [31:0] bch_cnt,
  output logic [31:0] mispred_cnt
);

  // resolve already excludes killed cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      bch_cnt     <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (resolve) begin
        bch_cnt <= bch_cnt + 32'd1;
      end
      if (resolve && mispredict) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/cv32e40x_bch_resolve.sv
// EX-stage branch resolution: checks the ID static prediction against the ALU
// outcome and holds a fetch redirect on mispredict. Optional counters: CV32E40X_BCH_PERF_CNT_EN.
module cv32e40x_bch_resolve
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic        ex_ready_i,
  input  logic        bch_id_i,
  input  logic        bch_prediction_id_i,
  input  logic [31:0] bch_target_id_i,
  input  logic [31:0] pc_id_i,
  input  logic        instr_compressed_id_i,
  input  logic        ex_valid_i,
  input  logic        branch_decision_ex_i,
  input  logic        kill_ex_i,
  input  logic        redirect_ack_i,
  output logic        redirect_req_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_if_id_o,
  output logic        ex_stall_o,
  output logic [31:0] bch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  bch_res_state_e state_q, state_n;
  logic        bch_q;
  logic        pred_q;
  logic [31:0] target_q;
  logic [31:0] fallthru_q;
  logic [31:0] pc_hold_q;

  logic        transfer;
  logic        resolve;
  logic        mispredict;
  logic [31:0] mis_pc;
  logic [31:0] fallthru;
  logic        hold_load;

  // Transfers arriving while a redirect is pending are dropped.
  assign transfer   = id_valid_i & ex_ready_i & (state_q == BR_IDLE);
  assign resolve    = bch_q & ex_valid_i & ~kill_ex_i;
  assign mispredict = branch_decision_ex_i != pred_q;
  assign mis_pc     = branch_decision_ex_i ? target_q : fallthru_q;
  assign fallthru   = pc_id_i + (instr_compressed_id_i ? PC_INC_16 : PC_INC_32);

  // State, EX branch register and held redirect address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BR_IDLE;
      bch_q      <= 1'b0;
      pred_q     <= 1'b0;
      target_q   <= 32'd0;
      fallthru_q <= 32'd0;
      pc_hold_q  <= 32'd0;
    end else begin
      state_q <= state_n;
      if (kill_ex_i) begin
        bch_q <= 1'b0;
      end else if (transfer) begin
        bch_q      <= bch_id_i;
        pred_q     <= bch_prediction_id_i;
        target_q   <= bch_target_id_i;
        fallthru_q <= fallthru;
      end else if (resolve) begin
        bch_q <= 1'b0;
      end
      if (hold_load) begin
        pc_hold_q <= mis_pc;
      end
    end
  end

  // Next state and redirect outputs.
  always_comb begin
    state_n        = state_q;
    redirect_req_o = 1'b0;
    redirect_pc_o  = 32'd0;
    flush_if_id_o  = 1'b0;
    ex_stall_o     = 1'b0;
    hold_load      = 1'b0;
    case (state_q)
      BR_IDLE: begin
        if (resolve && mispredict) begin
          redirect_req_o = 1'b1;
          redirect_pc_o  = mis_pc;
          flush_if_id_o  = 1'b1;
          if (!redirect_ack_i) begin
            hold_load = 1'b1;
            state_n   = BR_WAIT;
          end else begin
            state_n = BR_IDLE;
          end
        end else begin
          state_n = BR_IDLE;
        end
      end
      BR_WAIT: begin
        // A kill hands the redirect over to the controller.
        if (kill_ex_i) begin
          state_n = BR_IDLE;
        end else begin
          redirect_req_o = 1'b1;
          redirect_pc_o  = pc_hold_q;
          flush_if_id_o  = 1'b1;
          ex_stall_o     = 1'b1;
          if (redirect_ack_i) begin
            state_n = BR_IDLE;
          end else begin
            state_n = BR_WAIT;
          end
        end
      end
      default: begin
        state_n = BR_IDLE;
      end
    endcase
  end

`ifdef CV32E40X_BCH_PERF_CNT_EN
  cv32e40x_bch_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .resolve     (resolve),
    .mispredict  (mispredict),
    .bch_cnt     (bch_cnt_o),
    .mispred_cnt (mispred_cnt_o)
  );
`else
  assign bch_cnt_o     = 32'd0;
  assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cv32e40x_bch_resolve.sv
// Directed table-driven bench for cv32e40x_bch_resolve; counter expectations
// follow whether CV32E40X_BCH_PERF_CNT_EN is defined.
module tb_cv32e40x_bch_resolve;

`ifdef CV32E40X_BCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i, ex_ready_i, bch_id_i, bch_prediction_id_i;
  logic [31:0] bch_target_id_i, pc_id_i;
  logic        instr_compressed_id_i, ex_valid_i, branch_decision_ex_i;
  logic        kill_ex_i, redirect_ack_i;
  logic        redirect_req_o, flush_if_id_o, ex_stall_o;
  logic [31:0] redirect_pc_o, bch_cnt_o, mispred_cnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40x_bch_resolve dut (
    .clk                   (clk),
    .rst                   (rst),
    .id_valid_i            (id_valid_i),
    .ex_ready_i            (ex_ready_i),
    .bch_id_i              (bch_id_i),
    .bch_prediction_id_i   (bch_prediction_id_i),
    .bch_target_id_i       (bch_target_id_i),
    .pc_id_i               (pc_id_i),
    .instr_compressed_id_i (instr_compressed_id_i),
    .ex_valid_i            (ex_valid_i),
    .branch_decision_ex_i  (branch_decision_ex_i),
    .kill_ex_i             (kill_ex_i),
    .redirect_ack_i        (redirect_ack_i),
    .redirect_req_o        (redirect_req_o),
    .redirect_pc_o         (redirect_pc_o),
    .flush_if_id_o         (flush_if_id_o),
    .ex_stall_o            (ex_stall_o),
    .bch_cnt_o             (bch_cnt_o),
    .mispred_cnt_o         (mispred_cnt_o)
  );

  typedef struct {
    logic        rst;
    logic        tr;
    logic        pred;
    logic        comp;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        exv;
    logic        dec;
    logic        kill;
    logic        ack;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_stall;
    logic [31:0] e_bcnt;
    logic [31:0] e_mcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic tr, logic pred, logic comp,
                              logic [31:0] pc, logic [31:0] tgt, logic exv,
                              logic dec, logic kill, logic ack, logic e_req,
                              logic [31:0] e_pc, logic e_flush, logic e_stall,
                              logic [31:0] e_bcnt, logic [31:0] e_mcnt);
    vec_t v;
    v.rst = r; v.tr = tr; v.pred = pred; v.comp = comp; v.pc = pc; v.tgt = tgt;
    v.exv = exv; v.dec = dec; v.kill = kill; v.ack = ack;
    v.e_req = e_req; v.e_pc = e_pc; v.e_flush = e_flush; v.e_stall = e_stall;
    v.e_bcnt = PERF ? e_bcnt : 32'd0;
    v.e_mcnt = PERF ? e_mcnt : 32'd0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst                   = v.rst;
    id_valid_i            = v.tr;
    ex_ready_i            = v.tr;
    bch_id_i              = v.tr;
    bch_prediction_id_i   = v.pred;
    instr_compressed_id_i = v.comp;
    pc_id_i               = v.pc;
    bch_target_id_i       = v.tgt;
    ex_valid_i            = v.exv;
    branch_decision_ex_i  = v.dec;
    kill_ex_i             = v.kill;
    redirect_ack_i        = v.ack;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    check({t, ".req"},   {31'd0, redirect_req_o}, {31'd0, v.e_req});
    check({t, ".pc"},    redirect_pc_o, v.e_pc);
    check({t, ".flush"}, {31'd0, flush_if_id_o}, {31'd0, v.e_flush});
    check({t, ".stall"}, {31'd0, ex_stall_o}, {31'd0, v.e_stall});
    check({t, ".bcnt"},  bch_cnt_o, v.e_bcnt);
    check({t, ".mcnt"},  mispred_cnt_o, v.e_mcnt);
  endtask

  initial begin
    //         rst tr pr cm pc            tgt           exv dc kl ak | req pc           fl st bc mc
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,0, 0,32'h0,        0,0, 0,0)); // 0 reset state
    vecs.push_back(mk(0,1,1,0,32'h100,      32'hF0,       0,0,0,0, 0,32'h0,        0,0, 0,0)); // 1 backward br
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,0,0, 0,32'h0,        0,0, 0,0)); // 2 correct
    vecs.push_back(mk(0,1,0,0,32'h200,      32'h240,      0,0,0,0, 0,32'h0,        0,0, 1,0)); // 3 forward br
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,0,1, 1,32'h240,      1,0, 1,0)); // 4 mispred, ack
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,0, 0,32'h0,        0,0, 2,1)); // 5 idle
    vecs.push_back(mk(0,1,1,1,32'h300,      32'h2F0,      0,0,0,0, 0,32'h0,        0,0, 2,1)); // 6 compressed br
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,0,0,0, 1,32'h302,      1,0, 2,1)); // 7 mispred no ack
    vecs.push_back(mk(0,1,0,0,32'h800,      32'h900,      0,0,0,0, 1,32'h302,      1,1, 3,2)); // 8 WAIT, stray transfer
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,0, 1,32'h302,      1,1, 3,2)); // 9 WAIT
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,1, 1,32'h302,      1,1, 3,2)); // 10 WAIT ack
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,0,0, 0,32'h0,        0,0, 3,2)); // 11 idle, no branch in EX
    vecs.push_back(mk(0,1,0,0,32'h400,      32'h500,      0,0,0,0, 0,32'h0,        0,0, 3,2)); // 12
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,0,0, 1,32'h500,      1,0, 3,2)); // 13 mispred no ack
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,1,1, 0,32'h0,        0,0, 4,3)); // 14 WAIT kill+ack
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,0, 0,32'h0,        0,0, 4,3)); // 15 idle
    vecs.push_back(mk(0,1,0,0,32'h600,      32'h700,      0,0,0,0, 0,32'h0,        0,0, 4,3)); // 16
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,1,0, 0,32'h0,        0,0, 4,3)); // 17 killed resolve
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,1,0,0, 0,32'h0,        0,0, 4,3)); // 18 branch gone
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,0, 0,32'h0,        0,0, 4,3)); // 19
    vecs.push_back(mk(0,1,1,0,32'hFFFFFFFC, 32'h80,       0,0,0,0, 0,32'h0,        0,0, 4,3)); // 20 wrap br
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,0,0,0, 1,32'h0,        1,0, 4,3)); // 21 mispred -> 0
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,0, 1,32'h0,        1,1, 5,4)); // 22 WAIT
    vecs.push_back(mk(1,0,0,0,32'h0,        32'h0,        0,0,0,0, 1,32'h0,        1,1, 5,4)); // 23 rst in WAIT
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,0,0,0, 0,32'h0,        0,0, 0,0)); // 24 after rst

    drive(mk(1,0,0,0,32'h0,32'h0,0,0,0,0,0,32'h0,0,0,0,0));
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // Long unacknowledged redirect: request and address must stay stable.
    @(negedge clk);
    drive(mk(0,1,0,0,32'h1000,32'h1100,0,0,0,0,0,32'h0,0,0,0,0));
    @(negedge clk);
    drive(mk(0,0,0,0,32'h0,32'h0,1,1,0,0,0,32'h0,0,0,0,0));
    #1;
    check("long.first_pc", redirect_pc_o, 32'h1100);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      drive(mk(0,0,0,0,32'h0,32'h0,0,0,0,(k == 19) ? 1'b1 : 1'b0,0,32'h0,0,0,0,0));
      #1;
      check($sformatf("long.hold%0d", k),
            {redirect_req_o, ex_stall_o, flush_if_id_o, 29'd0} | {3'd0, redirect_pc_o[28:0]},
            {3'b111, 29'h1100});
    end
    @(negedge clk);
    drive(mk(0,0,0,0,32'h0,32'h0,0,0,0,0,0,32'h0,0,0,0,0));
    #1;
    check("long.released", {31'd0, redirect_req_o}, 32'd0);
    check("long.bcnt", bch_cnt_o, PERF ? 32'd1 : 32'd0);
    check("long.mcnt", mispred_cnt_o, PERF ? 32'd1 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
